// File: rtl/char_bit_serializer.sv
// char_bit_serializer
// Takes one character from a 1-entry buffer at each character-window rising
// edge and shifts it out MSB-first, holding each bit for BIT_CYCLES clocks.
// An empty buffer sends IDLE_CHAR and raises underrun. A window that falls
// before the character is complete raises abort and discards the character.
// Optional build macro CHAR_SER_STATS_EN adds saturating tx_count and
// urun_count outputs.
module char_bit_serializer #(
  parameter int                DATA_W     = 8,
  parameter int                BIT_CYCLES = 8,
  parameter logic [DATA_W-1:0] IDLE_CHAR  = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              win,
  input  logic [DATA_W-1:0] char_data,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              tx_bit,
  output logic              tx_en,
  output logic              char_done,
  output logic              underrun,
  output logic              abort
`ifdef CHAR_SER_STATS_EN
  ,
  output logic [15:0]       tx_count,
  output logic [15:0]       urun_count
`endif
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int IW = $clog2(DATA_W);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              win_d_r;
  logic              full_r, full_s;
  logic [DATA_W-1:0] buf_r, buf_s;
  logic [DATA_W-1:0] shreg_r, shreg_s;
  logic [IW-1:0]     bit_idx_r, bit_idx_s;
  logic [CW-1:0]     cyc_cnt_r, cyc_cnt_s;
  logic              tx_bit_s, tx_en_s, done_s, urun_s, abort_s;
  logic              win_start_s, wr_s, consume_s;

  // Next-state, datapath and registered-output values for the serializer FSM.
  always_comb begin
    state_s     = state_r;
    shreg_s     = shreg_r;
    bit_idx_s   = bit_idx_r;
    cyc_cnt_s   = cyc_cnt_r;
    tx_bit_s    = 1'b0;
    tx_en_s     = 1'b0;
    done_s      = 1'b0;
    urun_s      = 1'b0;
    abort_s     = 1'b0;
    consume_s   = 1'b0;
    win_start_s = win & ~win_d_r;
    // A write can only land when the buffer is empty, so it never collides
    // with a consume (which only happens when the buffer is full).
    wr_s        = char_valid & ~full_r;

    case (state_r)
      IDLE: begin
        if (win_start_s) begin
          state_s   = SHIFT;
          bit_idx_s = IDX_LAST;
          cyc_cnt_s = '0;
          tx_en_s   = 1'b1;
          if (full_r) begin
            shreg_s   = buf_r;
            tx_bit_s  = buf_r[DATA_W-1];
            consume_s = 1'b1;
          end else begin
            shreg_s   = IDLE_CHAR;
            tx_bit_s  = IDLE_CHAR[DATA_W-1];
            urun_s    = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (!win) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else if ((cyc_cnt_r == CYC_LAST) && (bit_idx_r == '0)) begin
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          tx_en_s   = 1'b1;
          cyc_cnt_s = cyc_cnt_r + CW'(1);
          if (cyc_cnt_r == CYC_LAST) begin
            bit_idx_s = bit_idx_r - IW'(1);
          end else begin
            bit_idx_s = bit_idx_r;
          end
          tx_bit_s = shreg_r[bit_idx_s];
        end
      end
      DONE: begin
        if (win) begin
          state_s = WAIT_LOW;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!win) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_LOW;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    full_s = wr_s ? 1'b1 : (consume_s ? 1'b0 : full_r);
    buf_s  = wr_s ? char_data : buf_r;
  end

  // State, buffer, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      win_d_r    <= 1'b0;
      full_r     <= 1'b0;
      buf_r      <= '0;
      shreg_r    <= '0;
      bit_idx_r  <= '0;
      cyc_cnt_r  <= '0;
      char_ready <= 1'b1;
      tx_bit     <= 1'b0;
      tx_en      <= 1'b0;
      char_done  <= 1'b0;
      underrun   <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state_r    <= state_s;
      win_d_r    <= win;
      full_r     <= full_s;
      buf_r      <= buf_s;
      shreg_r    <= shreg_s;
      bit_idx_r  <= bit_idx_s;
      cyc_cnt_r  <= cyc_cnt_s;
      char_ready <= ~full_s;
      tx_bit     <= tx_bit_s;
      tx_en      <= tx_en_s;
      char_done  <= done_s;
      underrun   <= urun_s;
      abort      <= abort_s;
    end
  end

`ifdef CHAR_SER_STATS_EN
  // Saturating counts of completed characters and underrun windows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_count   <= 16'h0000;
      urun_count <= 16'h0000;
    end else begin
      if (done_s && (tx_count != 16'hFFFF)) begin
        tx_count <= tx_count + 16'd1;
      end
      if (urun_s && (urun_count != 16'hFFFF)) begin
        urun_count <= urun_count + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_char_bit_serializer.sv
// Self-checking bench for char_bit_serializer: expected bits are queued when
// each window is driven and popped by a monitor whenever tx_en is high.
module tb_char_bit_serializer;

  localparam logic [7:0] IDLE_C = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       win = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready, tx_bit, tx_en, char_done, underrun, abort;
`ifdef CHAR_SER_STATS_EN
  logic [15:0] tx_count, urun_count;
`endif

  int checks = 0;
  int errors = 0;
  int n_txen = 0, n_done = 0, n_urun = 0, n_abort = 0;
  int exp_tx = 0, exp_urun = 0;
  bit mon_en = 1'b0;
  bit model_full = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic exp_b;
  logic bit_q[$];

  char_bit_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .win        (win),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .tx_bit     (tx_bit),
    .tx_en      (tx_en),
    .char_done  (char_done),
    .underrun   (underrun),
    .abort      (abort)
`ifdef CHAR_SER_STATS_EN
    ,
    .tx_count   (tx_count),
    .urun_count (urun_count)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: compare every serialized bit against the scoreboard, count pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_en === 1'b1) begin
        n_txen++;
        checks++;
        if (bit_q.size() == 0) begin
          errors++;
          $display("FAIL tx_bit_extra: tx_en high with nothing expected, tx_bit=%b", tx_bit);
        end else begin
          exp_b = bit_q.pop_front();
          if (tx_bit !== exp_b) begin
            errors++;
            $display("FAIL tx_bit: got %b expected %b at %0t", tx_bit, exp_b, $time);
          end
        end
      end else begin
        checks++;
        if (tx_bit !== 1'b0) begin
          errors++;
          $display("FAIL tx_bit_idle: got %b expected 0 while tx_en low at %0t", tx_bit, $time);
        end
      end
      if (char_done === 1'b1) n_done++;
      if (underrun === 1'b1) n_urun++;
      if (abort === 1'b1) n_abort++;
    end
  end

  task automatic check_quiet(input string tag);
    checks++;
    if ({tx_bit, tx_en, char_done, underrun, abort, char_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL %s: tx_bit,tx_en,done,urun,abort,ready=%b expected 000001", tag,
               {tx_bit, tx_en, char_done, underrun, abort, char_ready});
    end
`ifdef CHAR_SER_STATS_EN
    checks++;
    if ({tx_count, urun_count} !== 32'h0) begin
      errors++;
      $display("FAIL %s_stats: tx_count=%0d urun_count=%0d expected 0", tag, tx_count, urun_count);
    end
`endif
  endtask

  task automatic write_char(input logic [7:0] c);
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_write: char_ready=%b expected 1", char_ready);
    end
    char_valid = 1'b1;
    char_data  = c;
    @(posedge clk); #1;
    char_valid = 1'b0;
    model_full = 1'b1;
    model_data = c;
    checks++;
    if (char_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_write: char_ready=%b expected 0", char_ready);
    end
  endtask

  // Drive one window of len cycles; optionally present a char at the E0 edge.
  task automatic run_window(input int len, input bit wr, input logic [7:0] wc);
    logic [7:0] ec;
    bit eu, ab;
    int ntx, d0, u0, a0, t0;
    eu = !model_full;
    ec = model_full ? model_data : IDLE_C;
    model_full = 1'b0;
    if (wr) begin
      model_full = 1'b1;
      model_data = wc;
    end
    ntx = (len < 64) ? len : 64;
    ab  = (len < 65);
    for (int i = 0; i < ntx; i++) bit_q.push_back(ec[7 - i / 8]);
    if (!ab) exp_tx++;
    if (eu) exp_urun++;
    d0 = n_done; u0 = n_urun; a0 = n_abort; t0 = n_txen;
    win = 1'b1;
    if (wr) begin
      char_valid = 1'b1;
      char_data  = wc;
    end
    @(posedge clk); #1;
    char_valid = 1'b0;
    checks++;
    if (underrun !== eu) begin
      errors++;
      $display("FAIL underrun_e0: got %b expected %b", underrun, eu);
    end
    checks++;
    if (tx_en !== 1'b1) begin
      errors++;
      $display("FAIL tx_en_e0: got %b expected 1", tx_en);
    end
    checks++;
    if (char_ready !== !model_full) begin
      errors++;
      $display("FAIL ready_e0: got %b expected %b", char_ready, !model_full);
    end
    repeat (len - 1) @(posedge clk);
    #1 win = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (n_txen - t0 != ntx) begin
      errors++;
      $display("FAIL tx_en_cycles: got %0d expected %0d", n_txen - t0, ntx);
    end
    checks++;
    if (n_done - d0 != int'(!ab)) begin
      errors++;
      $display("FAIL char_done_count: got %0d expected %0d", n_done - d0, int'(!ab));
    end
    checks++;
    if (n_abort - a0 != int'(ab)) begin
      errors++;
      $display("FAIL abort_count: got %0d expected %0d", n_abort - a0, int'(ab));
    end
    checks++;
    if (n_urun - u0 != int'(eu)) begin
      errors++;
      $display("FAIL underrun_count: got %0d expected %0d", n_urun - u0, int'(eu));
    end
    checks++;
    if (bit_q.size() != 0) begin
      errors++;
      $display("FAIL bits_left: %0d expected bits never sent", bit_q.size());
      bit_q.delete();
    end
  endtask

  task automatic test_reset;
    #23;
    check_quiet("reset_state");
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check_quiet("after_release");
  endtask

  task automatic test_basic;
    write_char(8'hA5);
    run_window(65, 1'b0, 8'h00);
  endtask

  task automatic test_underrun;
    run_window(65, 1'b0, 8'h00);
  endtask

  task automatic test_abort;
    write_char(8'hFF);
    run_window(20, 1'b0, 8'h00);
    run_window(65, 1'b0, 8'h00);
  endtask

  task automatic test_simultaneous;
    run_window(65, 1'b1, 8'hC3);
    run_window(65, 1'b0, 8'h00);
  endtask

  task automatic test_hold_high;
    write_char(8'h3C);
    run_window(200, 1'b0, 8'h00);
  endtask

  task automatic test_async_reset;
    write_char(8'h5A);
    mon_en = 1'b0;
    win = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (tx_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_shift: tx_en=%b expected 1 before reset", tx_en);
    end
    #2 reset = 1'b0;
    #1 check_quiet("async_reset");
    win = 1'b0;
    bit_q.delete();
    model_full = 1'b0;
    exp_tx = 0;
    exp_urun = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check_quiet("after_async_release");
    run_window(65, 1'b0, 8'h00);
  endtask

  task automatic test_stats;
    write_char(8'hA5);
    run_window(65, 1'b0, 8'h00);
    write_char(8'h3C);
    run_window(65, 1'b0, 8'h00);
    run_window(65, 1'b0, 8'h00);
    write_char(8'h81);
    run_window(65, 1'b0, 8'h00);
`ifdef CHAR_SER_STATS_EN
    checks++;
    if (tx_count !== 16'(exp_tx)) begin
      errors++;
      $display("FAIL tx_count: got %0d expected %0d", tx_count, exp_tx);
    end
    checks++;
    if (urun_count !== 16'(exp_urun)) begin
      errors++;
      $display("FAIL urun_count: got %0d expected %0d", urun_count, exp_urun);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_underrun;
    test_abort;
    test_simultaneous;
    test_hold_high;
    test_async_reset;
    test_stats;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
